// File: rtl/bp_me_clint_regfile.sv
// CLINT register storage (mtime, mtimecmp, msip) behind the register adapter.
// One-hot sync strobes in; per-register read data latched one cycle later.
module bp_me_clint_regfile
  #(parameter int paddr_width_p    = 40
   ,parameter int reg_addr_width_p = paddr_width_p
   ,parameter int tick_div_p       = 8
   )
   (input  logic                        clk_i
   ,input  logic                        reset_i
   ,input  logic [2:0]                  r_v_i
   ,input  logic [2:0]                  w_v_i
   ,input  logic [reg_addr_width_p-1:0] addr_i
   ,input  logic [1:0]                  size_i
   ,input  logic [63:0]                 data_i
   ,output logic [2:0][63:0]            data_o
   ,output logic                        timer_irq_o
   ,output logic                        software_irq_o
   );

   localparam int pw_lp = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
   localparam logic [pw_lp-1:0] tick_max_lp = pw_lp'(tick_div_p - 1);

   logic [63:0]      mtime_q, mtime_d;
   logic [63:0]      mtimecmp_q, mtimecmp_d;
   logic             msip_q, msip_d;
   logic [pw_lp-1:0] presc_q, presc_d;
   logic [2:0][63:0] data_q, data_d;
   logic             timer_irq_q, timer_irq_d;
   logic             sw_irq_q, sw_irq_d;

   logic [2:0]  off;
   logic [5:0]  sh;
   logic [7:0]  len_mask, wmask;
   logic [63:0] wdata, wbits, rmask;
   logic        tick;

   // Lane masks: shifting the 8-bit mask drops lanes past byte 7
   always_comb begin
      off = addr_i[2:0];
      sh  = {off, 3'b000};
      unique case (size_i)
         2'd0:    len_mask = 8'h01;
         2'd1:    len_mask = 8'h03;
         2'd2:    len_mask = 8'h0f;
         default: len_mask = 8'hff;
      endcase
      wmask = len_mask << off;
      wdata = data_i << sh;
      wbits = '0;
      rmask = '0;
      for (int b = 0; b < 8; b++) begin
         wbits[8*b +: 8] = {8{wmask[b]}};
         rmask[8*b +: 8] = {8{len_mask[b]}};
      end
   end

   always_comb begin
      tick       = (presc_q == tick_max_lp);
      presc_d    = tick ? '0 : presc_q + pw_lp'(1);
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      data_d     = data_q;
      if (w_v_i[0]) begin
         mtime_d = (mtime_q & ~wbits) | (wdata & wbits);
         presc_d = '0;
      end
      if (w_v_i[1])
         mtimecmp_d = (mtimecmp_q & ~wbits) | (wdata & wbits);
      if (w_v_i[2] && wmask[0])
         msip_d = wdata[0];
      // Reads see pre-increment state
      if (r_v_i[0]) data_d[0] = (mtime_q >> sh) & rmask;
      if (r_v_i[1]) data_d[1] = (mtimecmp_q >> sh) & rmask;
      if (r_v_i[2]) data_d[2] = ({63'b0, msip_q} >> sh) & rmask;
      timer_irq_d = (mtime_d >= mtimecmp_d);
      sw_irq_d    = msip_d;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mtime_q     <= '0;
         mtimecmp_q  <= '1;
         msip_q      <= 1'b0;
         presc_q     <= '0;
         data_q      <= '0;
         timer_irq_q <= 1'b0;
         sw_irq_q    <= 1'b0;
      end else begin
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         msip_q      <= msip_d;
         presc_q     <= presc_d;
         data_q      <= data_d;
         timer_irq_q <= timer_irq_d;
         sw_irq_q    <= sw_irq_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i)
         assert ($onehot0({r_v_i, w_v_i}));
   end

   assign data_o         = data_q;
   assign timer_irq_o    = timer_irq_q;
   assign software_irq_o = sw_irq_q;

endmodule

// File: tb/tb_bp_me_clint_regfile.sv
// Scoreboard bench for bp_me_clint_regfile: driver pushes expectations,
// monitor pops and compares one edge later.
module tb_bp_me_clint_regfile;

   localparam int AW = 40;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       r_v, w_v;
   logic [AW-1:0]    addr;
   logic [1:0]       size;
   logic [63:0]      data;
   logic [2:0][63:0] data_o;
   logic             timer_irq, sw_irq;

   always #5 clk = ~clk;

   bp_me_clint_regfile #(.paddr_width_p(AW), .reg_addr_width_p(AW), .tick_div_p(8)) dut
     (.clk_i(clk)
     ,.reset_i(reset)
     ,.r_v_i(r_v)
     ,.w_v_i(w_v)
     ,.addr_i(addr)
     ,.size_i(size)
     ,.data_i(data)
     ,.data_o(data_o)
     ,.timer_irq_o(timer_irq)
     ,.software_irq_o(sw_irq)
     );

   typedef struct {
      int          cyc;
      int          kind;
      logic [63:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;

   // kind 0..2: data_o[kind], 3: timer irq, 4: software irq
   task automatic push(input int kind, input logic [63:0] v, input string n);
      exp_t e;
      e.cyc  = cyc + 1;
      e.kind = kind;
      e.val  = v;
      e.name = n;
      sb.push_back(e);
   endtask

   task automatic drive(input logic rst, input logic [2:0] r, input logic [2:0] w,
                        input logic [2:0] off, input logic [1:0] sz, input logic [63:0] d);
      @(negedge clk);
      reset = rst;
      r_v   = r;
      w_v   = w;
      addr  = {{(AW-3){1'b0}}, off};
      size  = sz;
      data  = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 3'b000, 3'b000, 3'd0, 2'd0, 64'd0);
   endtask

   initial begin : monitor
      exp_t        e;
      logic [63:0] act;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
               0:       act = data_o[0];
               1:       act = data_o[1];
               2:       act = data_o[2];
               3:       act = {63'b0, timer_irq};
               default: act = {63'b0, sw_irq};
            endcase
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
               errors++;
               $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                        e.name, act, e.val, cyc, e.cyc);
            end
         end
      end
   end

   initial begin : stim
      reset = 1'b1; r_v = '0; w_v = '0; addr = '0; size = '0; data = '0;
      drive(1'b1, 3'b000, 3'b000, 3'd0, 2'd0, 64'd0);
      drive(1'b1, 3'b000, 3'b000, 3'd0, 2'd0, 64'd0);
      push(0, 64'd0, "rst_data0"); push(1, 64'd0, "rst_data1");
      push(2, 64'd0, "rst_data2"); push(3, 64'd0, "rst_timer");
      push(4, 64'd0, "rst_sw");

      // Prescaler: mtime bumps on the 8th edge after reset release
      idle(6);
      drive(1'b0, 3'b001, 3'b000, 3'd0, 2'd3, 64'd0); push(0, 64'd0, "mtime_e7");
      idle(1);
      drive(1'b0, 3'b001, 3'b000, 3'd0, 2'd3, 64'd0); push(0, 64'd1, "mtime_e9");
      idle(7);
      drive(1'b0, 3'b001, 3'b000, 3'd0, 2'd3, 64'd0); push(0, 64'd2, "mtime_e17");

      // Timer compare
      drive(1'b0, 3'b000, 3'b010, 3'd0, 2'd3, 64'd5); push(3, 64'd0, "timer_cmp5");
      drive(1'b0, 3'b000, 3'b001, 3'd0, 2'd3, 64'd0); push(3, 64'd0, "timer_mt0");
      idle(38);
      idle(1); push(3, 64'd0, "timer_mt4");
      idle(1); push(3, 64'd1, "timer_rise");
      drive(1'b0, 3'b001, 3'b000, 3'd0, 2'd3, 64'd0);
      push(0, 64'd5, "mtime_5"); push(3, 64'd1, "timer_hold");
      drive(1'b0, 3'b000, 3'b010, 3'd0, 2'd3, '1); push(3, 64'd0, "timer_fall");

      // msip
      drive(1'b0, 3'b000, 3'b100, 3'd0, 2'd3, 64'h3); push(4, 64'd1, "sw_rise");
      drive(1'b0, 3'b100, 3'b000, 3'd0, 2'd3, 64'd0);
      push(2, 64'd1, "msip_read"); push(4, 64'd1, "sw_hold");
      drive(1'b0, 3'b000, 3'b100, 3'd0, 2'd3, 64'd0); push(4, 64'd0, "sw_fall");

      // Partial writes / reads on mtimecmp
      drive(1'b0, 3'b000, 3'b010, 3'd0, 2'd3, 64'h1111_2222_3333_4444);
      drive(1'b0, 3'b000, 3'b010, 3'd2, 2'd0, 64'hAB);
      drive(1'b0, 3'b010, 3'b000, 3'd0, 2'd3, 64'd0);
      push(1, 64'h1111_2222_33AB_4444, "cmp_byte2");
      drive(1'b0, 3'b010, 3'b000, 3'd4, 2'd1, 64'd0); push(1, 64'h2222, "cmp_rd_h_off4");
      drive(1'b0, 3'b010, 3'b000, 3'd4, 2'd2, 64'd0);
      push(1, 64'h1111_2222, "cmp_rd_w_off4"); push(0, 64'd5, "data0_latched");
      drive(1'b0, 3'b000, 3'b010, 3'd7, 2'd1, 64'hCDEF);
      drive(1'b0, 3'b010, 3'b000, 3'd0, 2'd3, 64'd0);
      push(1, 64'hEF11_2222_33AB_4444, "cmp_misalign");
      drive(1'b0, 3'b010, 3'b000, 3'd7, 2'd0, 64'd0); push(1, 64'hEF, "cmp_rd_b7");

      // mtime write wins over a due increment
      drive(1'b0, 3'b000, 3'b001, 3'd0, 2'd3, 64'h20);
      idle(7);
      drive(1'b0, 3'b000, 3'b001, 3'd0, 2'd3, 64'h10);
      drive(1'b0, 3'b001, 3'b000, 3'd0, 2'd3, 64'd0); push(0, 64'h10, "mt_write_wins");
      idle(6);
      drive(1'b0, 3'b001, 3'b000, 3'd0, 2'd3, 64'd0); push(0, 64'h10, "mt_pre_tick");
      drive(1'b0, 3'b001, 3'b000, 3'd0, 2'd3, 64'd0); push(0, 64'h11, "mt_post_tick");

      // mtime wrap with cmp = 0
      drive(1'b0, 3'b000, 3'b010, 3'd0, 2'd3, 64'd0); push(3, 64'd1, "timer_cmp0");
      drive(1'b0, 3'b000, 3'b001, 3'd0, 2'd3, '1); push(3, 64'd1, "timer_mtmax");
      idle(6);
      drive(1'b0, 3'b001, 3'b000, 3'd4, 2'd2, 64'd0); push(0, 64'hFFFF_FFFF, "mt_rd_hi");
      drive(1'b0, 3'b001, 3'b000, 3'd0, 2'd3, 64'd0); push(0, '1, "mt_max");
      drive(1'b0, 3'b001, 3'b000, 3'd0, 2'd3, 64'd0);
      push(0, 64'd0, "mt_wrap"); push(3, 64'd1, "timer_wrap");

      // Reset in the middle of writes
      drive(1'b0, 3'b000, 3'b100, 3'd0, 2'd3, 64'h1); push(4, 64'd1, "sw_pre_rst");
      drive(1'b1, 3'b000, 3'b010, 3'd0, 2'd3, 64'h77);
      push(0, 64'd0, "mid_rst_d0"); push(1, 64'd0, "mid_rst_d1");
      push(2, 64'd0, "mid_rst_d2"); push(3, 64'd0, "mid_rst_timer");
      push(4, 64'd0, "mid_rst_sw");
      drive(1'b0, 3'b001, 3'b000, 3'd0, 2'd3, 64'd0); push(0, 64'd0, "post_rst_mt");
      drive(1'b0, 3'b010, 3'b000, 3'd0, 2'd3, 64'd0);
      push(1, '1, "post_rst_cmp"); push(3, 64'd0, "post_rst_timer");
      drive(1'b0, 3'b100, 3'b000, 3'd0, 2'd3, 64'd0); push(2, 64'd0, "post_rst_msip");
      idle(1);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
         errors += sb.size();
         checks += sb.size();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
